seq_divider_8by4: RTL
=====================

# seq_divider_8by4

Multi-cycle restoring divider: 8-bit dividend by 4-bit divisor, producing an 8-bit quotient and 4-bit remainder. It is the inverse of the team's 4x4 pipelined multiplier and is used to recover a factor from an 8-bit product. It sits behind the TinyTapeout pin wrapper. Operand capture and completion use a start/busy/done handshake.

## Interface
- WIDTH_N, default 8: dividend and quotient width.
- WIDTH_D, default 4: divisor and remainder width. The defaults are the only supported configuration.

- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  enable. When low, all registers hold (global stall).
- start  in  1  request. Sampled on a clk edge with ena=1.
- dividend  in  8  numerator, captured on an accepted start.
- divisor  in  4  denominator, captured on an accepted start.
- quotient  out  8  result, registered.
- remainder  out  4  result, registered.
- busy  out  1  high while an iteration is in progress.
- done  out  1  one-cycle completion strobe.
- div_by_zero  out  1  set when the captured divisor is 0. Held with the results.

## Operation
- FSM has three states: IDLE, CALC, DONE.
- Start is accepted on any edge with ena=1 and start=1 while in IDLE or DONE. In CALC, start is ignored and operands are not re-sampled.
- On acceptance:
  - Capture D=divisor.
  - Set working quotient Wq=dividend.
  - Clear the 5-bit partial remainder Wr=0.
  - Set the iteration counter to 8.
  - If divisor!=0, go to CALC. If divisor==0, go directly to DONE.
- CALC does one iteration per enabled edge, 8 iterations total:
  - t = {Wr[3:0], Wq[7]}; Wq shifts left by 1.
  - If t >= {0,D}: Wr = t - D and Wq[0]=1. Otherwise Wr = t and Wq[0]=0.
  - The comparison is unsigned, 5 bits wide.
  - The counter decrements. On the edge it reaches 0, go to DONE and load quotient=Wq (final) and remainder=Wr[3:0].
- Divide by zero: on the acceptance edge, load quotient=8'hFF, remainder=4'hF and div_by_zero=1.
- For normal completion, div_by_zero is loaded as 0 on the completion edge.
- DONE lasts exactly one enabled cycle. After that the FSM returns to IDLE, or to CALC/DONE if start is accepted on that edge (back-to-back operation).
- quotient, remainder and div_by_zero change only on completion edges. They hold across IDLE and throughout the next CALC.
- Invariant: quotient*divisor + remainder == dividend, with remainder < divisor, for every divisor != 0.

## Timing
- Reset: state=IDLE and all outputs 0 (quotient=0, remainder=0, busy=0, done=0, div_by_zero=0). Working registers are also cleared.
- Reset asserted mid-CALC aborts the operation immediately and asynchronously. There is no completion and no done.
- Normal latency, counted in enabled edges, with E0 as the edge that accepts start:
  - busy=1 after E0 through E7 (8 cycles).
  - Iterations occur at E1..E8.
  - After E8: busy=0, done=1 for one cycle, results valid.
- Divide-by-zero latency: done=1 and results valid in the cycle right after E0. busy is never asserted.
- ena=0 freezes state, counter, busy, done and outputs. A done pulse pending under ena=0 stays high until the next enabled edge.
- Throughput: one division per 9 enabled cycles (start accepted in DONE).

## Test plan
- Reset, then dividend=143, divisor=11, start for one cycle:
  - busy high for exactly 8 cycles.
  - done then pulses once with quotient=13, remainder=0, div_by_zero=0.
- 255/1 gives quotient=255, remainder=0. 200/15 gives 13 r 5. 7/9 gives 0 r 7. Results are held stable in IDLE until the next start.
- Divisor=0, dividend=77:
  - done in the cycle after start.
  - quotient=8'hFF, remainder=4'hF, div_by_zero=1, busy never high.
  - Then 50/7 gives 7 r 1 with div_by_zero cleared.
- start re-asserted with 99/4 during CALC of 143/11: it is ignored, and the result is 13 r 0.
- Start asserted during the done cycle of 200/15 (back-to-back):
  - The new operation starts with no idle gap.
  - The previous results stay visible until the second done.
- ena dropped for 3 cycles mid-CALC: completion is delayed by exactly 3 cycles and the result is unchanged.
- rst_n pulsed low mid-CALC: all outputs return to 0 immediately and no done follows.
- Random sweep over all 4096 operand pairs, checked against the invariant.

Source files
------------

// File: rtl/seq_divider_8by4.sv
// seq_divider_8by4: multi-cycle restoring divider, 8-bit dividend by 4-bit divisor.
// One quotient bit is resolved per enabled clock; operands are captured on start
// and results are published only on completion edges, behind a start/busy/done handshake.
module seq_divider_8by4 #(
   parameter int WIDTH_N = 8,
   parameter int WIDTH_D = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               start,
   input  logic [WIDTH_N-1:0] dividend,
   input  logic [WIDTH_D-1:0] divisor,
   output logic [WIDTH_N-1:0] quotient,
   output logic [WIDTH_D-1:0] remainder,
   output logic               busy,
   output logic               done,
   output logic               div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH_N + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_stateNext;

   logic [WIDTH_D-1:0]   r_d;
   logic [WIDTH_N-1:0]   r_wq;
   // After every restoring step the partial remainder is below the divisor,
   // so its top bit is always zero and only the low bits need storing.
   logic [WIDTH_D-1:0]   r_wr;
   logic [CNT_W-1:0]     r_count;

   logic                 w_accept;
   logic                 w_divZero;
   logic                 w_lastIter;
   logic [WIDTH_D:0]     w_trial;
   logic                 w_fits;
   logic [WIDTH_D-1:0]   w_wrNext;
   logic [WIDTH_N-1:0]   w_wqNext;

   assign w_accept   = ena && start && (r_state != S_CALC);
   assign w_divZero  = (divisor == '0);
   assign w_lastIter = (r_count == CNT_W'(1));

   // One restoring step: shift the next dividend bit into the partial remainder,
   // subtract the divisor when it fits, and record the outcome as a quotient bit.
   assign w_trial  = {r_wr, r_wq[WIDTH_N-1]};
   assign w_fits   = (w_trial >= {1'b0, r_d});
   assign w_wrNext = w_fits ? WIDTH_D'(w_trial - {1'b0, r_d}) : w_trial[WIDTH_D-1:0];
   assign w_wqNext = {r_wq[WIDTH_N-2:0], w_fits};

   // State register; ena low freezes the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else if (ena) begin
         r_state <= w_stateNext;
      end
   end

   // Next-state and handshake decode; a zero divisor skips straight to DONE.
   always_comb begin
      w_stateNext = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_stateNext = w_divZero ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            busy = 1'b1;
            if (w_lastIter) begin
               w_stateNext = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (w_accept) begin
               w_stateNext = w_divZero ? S_DONE : S_CALC;
            end else begin
               w_stateNext = S_IDLE;
            end
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   // Working registers: load operands on acceptance, then iterate once per enabled edge in CALC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d     <= '0;
         r_wq    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else if (ena) begin
         if (w_accept) begin
            r_d     <= divisor;
            r_wq    <= dividend;
            r_wr    <= '0;
            r_count <= CNT_W'(WIDTH_N);
         end else if (r_state == S_CALC) begin
            r_wq    <= w_wqNext;
            r_wr    <= w_wrNext;
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Published results change only on completion edges and otherwise hold, even through the next CALC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (ena) begin
         if (w_accept && w_divZero) begin
            quotient    <= '1;
            remainder   <= '1;
            div_by_zero <= 1'b1;
         end else if ((r_state == S_CALC) && w_lastIter) begin
            quotient    <= w_wqNext;
            remainder   <= w_wrNext;
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule
